// File: rtl/serial_capture_if.sv
// ---------------------------------------------------------------------------
// serial_capture_if
// Groups the serial line, the consumer handshake and the status outputs of
// serial_capture into one bundle.
//
// Signals:
//   data      serial line into the capture block, idle high
//   ack       consumer acknowledge of the presented word
//   q         last captured data word (WIDTH bits)
//   valid     q holds an unacknowledged word
//   frame_err sticky flag: a frame was received with a bad stop or parity bit
//   overrun   sticky flag: a good frame arrived while a word was still pending
//   busy      receiver is inside a frame
//
// Modports:
//   slave  - the capture block (drives q/valid/flags, reads data/ack)
//   master - the line driver and consumer side
// ---------------------------------------------------------------------------
interface serial_capture_if #(
  parameter int WIDTH = 8
) ();

  logic             data;
  logic             ack;
  logic [WIDTH-1:0] q;
  logic             valid;
  logic             frame_err;
  logic             overrun;
  logic             busy;

  modport slave (
    input  data,
    input  ack,
    output q,
    output valid,
    output frame_err,
    output overrun,
    output busy
  );

  modport master (
    output data,
    output ack,
    input  q,
    input  valid,
    input  frame_err,
    input  overrun,
    input  busy
  );

endinterface

// File: rtl/serial_capture.sv
// ---------------------------------------------------------------------------
// serial_capture
// Receives frames on a one-bit-per-clock serial line: start bit 0, WIDTH data
// bits LSB first, optional even-parity bit, stop bit 1. A good frame is
// presented on q with valid until the consumer acknowledges it.
//
// Optional feature macro: PARITY_CHECK_EN
//   defined   - frames carry an even-parity bit after the data bits; a parity
//               mismatch is treated like a bad stop bit.
//   undefined - no parity bit, no parity state or logic.
//
// Ports:
//   clock  rising-edge clock for all state
//   clear  asynchronous active-low reset
//   bus    serial_capture_if.slave: data, ack in; q, valid, frame_err,
//          overrun, busy out
// ---------------------------------------------------------------------------
module serial_capture #(
  parameter int WIDTH = 8
) (
  input  logic            clock,
  input  logic            clear,
  serial_capture_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
`ifdef PARITY_CHECK_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q,  word_d;
  logic             valid_q, valid_d;
  logic             ferr_q,  ferr_d;
  logic             ovr_q,   ovr_d;
`ifdef PARITY_CHECK_EN
  logic             par_q,   par_d;
`endif

  logic frame_done;
  logic frame_ok;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef PARITY_CHECK_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    word_d     = word_q;
    valid_d    = valid_q;
    ferr_d     = ferr_q;
    ovr_d      = ovr_q;
`ifdef PARITY_CHECK_EN
    par_d      = par_q;
`endif
    frame_done = 1'b0;
    frame_ok   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.data) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end

      DATA: begin
        // Write the sampled bit into its slot; earlier slots keep their value.
        for (int i = 0; i < WIDTH; i++) begin
          if (cnt_q == CNT_W'(i)) shift_d[i] = bus.data;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end

`ifdef PARITY_CHECK_EN
      PARITY: begin
        par_d   = bus.data;
        state_d = STOP;
      end
`endif

      STOP: begin
        // The stop bit is consumed here; the next bit is looked at in IDLE,
        // so a 0 stop bit can never be mistaken for a start bit.
        state_d    = IDLE;
        frame_done = 1'b1;
`ifdef PARITY_CHECK_EN
        // Even parity: data bits XOR parity bit must be 0.
        frame_ok   = bus.data & ~(^shift_q ^ par_q);
`else
        frame_ok   = bus.data;
`endif
      end

      default: state_d = IDLE;
    endcase

    if (frame_done && !frame_ok) begin
      ferr_d = 1'b1;
    end

    if (frame_done && frame_ok) begin
      if (valid_q && !bus.ack) begin
        // Pending word not yet taken: drop the new one, keep q stable.
        ovr_d = 1'b1;
      end else begin
        // Either nothing pending or it is acknowledged on this very edge.
        word_d  = shift_q;
        valid_d = 1'b1;
      end
    end else if (valid_q && bus.ack) begin
      valid_d = 1'b0;
    end
  end

  assign bus.q         = word_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_capture.sv
// ---------------------------------------------------------------------------
// tb_serial_capture
// Self-checking bench for serial_capture (WIDTH=8). Frames are built from
// the frame format directly; a small event-level model of the output
// register and flags predicts q/valid/frame_err/overrun/busy after every
// clock edge. Compile with +define+PARITY_CHECK_EN to exercise parity.
// ---------------------------------------------------------------------------
module tb_serial_capture;

`ifdef PARITY_CHECK_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 10;
`endif

  logic clock;
  logic clear;

  serial_capture_if #(.WIDTH(8)) bus ();

  serial_capture #(.WIDTH(8)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests;
  int fails;

  // Reference model state
  logic [7:0] m_q;
  logic       m_valid, m_err, m_ovr, m_busy;

  typedef struct {
    logic       pre_ack;
    logic [7:0] word;
    logic       stop;
    logic       ack_stop;
    logic [7:0] eq;
    logic       ev;
    logic       ee;
    logic       eo;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string name);
    logic [11:0] got, exp;
    got = {bus.q, bus.valid, bus.frame_err, bus.overrun, bus.busy};
    exp = {m_q, m_valid, m_err, m_ovr, m_busy};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got q=%h v=%b e=%b o=%b b=%b expected q=%h v=%b e=%b o=%b b=%b",
               name, $time, got[11:4], got[3], got[2], got[1], got[0],
               exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic model_clear();
    m_q = '0; m_valid = 0; m_err = 0; m_ovr = 0; m_busy = 0;
  endtask

  // ev: 0 = plain bit, 1 = start bit, 2 = stop bit (ok = frame good)
  task automatic step(input logic d, input logic a, input int ev,
                      input logic [7:0] w, input bit ok);
    bus.data = d;
    bus.ack  = a;
    @(posedge clock);
    if (ev == 2) begin
      m_busy = 0;
      if (!ok) m_err = 1;
      if (ok) begin
        if (m_valid && !a) m_ovr = 1;
        else begin
          m_q     = w;
          m_valid = 1;
        end
      end else if (m_valid && a) m_valid = 0;
    end else begin
      if (m_valid && a) m_valid = 0;
      if (ev == 1) m_busy = 1;
    end
    #1;
    check_all("cycle");
  endtask

  task automatic send_frame(input logic [7:0] w, input logic stop, input bit pflip,
                            input logic ack_stop, input bit rnd);
    step(1'b0, rnd ? ($urandom_range(0, 3) == 0) : 1'b0, 1, w, 1'b0);
    for (int i = 0; i < 8; i++)
      step(w[i], rnd ? ($urandom_range(0, 3) == 0) : 1'b0, 0, w, 1'b0);
`ifdef PARITY_CHECK_EN
    step((^w) ^ pflip, rnd ? ($urandom_range(0, 3) == 0) : 1'b0, 0, w, 1'b0);
`endif
    step(stop, ack_stop, 2, w, stop && !pflip);
  endtask

  task automatic do_reset();
    bus.data = 1'b1;
    bus.ack  = 1'b0;
    clear    = 1'b0;
    #1;
    model_clear();
    check_all("reset_state");
    @(posedge clock);
    #1;
    clear = 1'b1;
  endtask

  initial begin
    int lat;
    tests = 0;
    fails = 0;
    bus.data = 1'b1;
    bus.ack  = 1'b0;
    clear    = 1'b1;
    model_clear();

    tbl[0] = '{1'b0, 8'h9A, 1'b1, 1'b0, 8'h9A, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h55, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 8'hFF, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1};

    @(posedge clock);
    #1;
    do_reset();

    // Latency of the first frame, counted in edges from the start-bit edge.
    lat = 0;
    step(1'b0, 1'b0, 1, 8'h9A, 1'b0);
    if (bus.valid && lat == 0) lat = 1;
    for (int i = 0; i < 8; i++) begin
      step(tbl[0].word[i], 1'b0, 0, 8'h9A, 1'b0);
      if (bus.valid && lat == 0) lat = i + 2;
    end
`ifdef PARITY_CHECK_EN
    step(^tbl[0].word, 1'b0, 0, 8'h9A, 1'b0);
    if (bus.valid && lat == 0) lat = 10;
`endif
    step(1'b1, 1'b0, 2, 8'h9A, 1'b1);
    if (bus.valid && lat == 0) lat = LAT;
    chk("latency_edges", lat, LAT);
    chk("first_q", bus.q, 8'h9A);
    chk("first_ferr", bus.frame_err, 1'b0);

    // Directed table from a fresh reset.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      if (tbl[k].pre_ack) step(1'b1, 1'b1, 0, 8'h00, 1'b0);
      send_frame(tbl[k].word, tbl[k].stop, 1'b0, tbl[k].ack_stop, 1'b0);
      chk($sformatf("tbl%0d_q", k), bus.q, tbl[k].eq);
      chk($sformatf("tbl%0d_valid", k), bus.valid, tbl[k].ev);
      chk($sformatf("tbl%0d_ferr", k), bus.frame_err, tbl[k].ee);
      chk($sformatf("tbl%0d_ovr", k), bus.overrun, tbl[k].eo);
    end

    // Asynchronous clear mid-frame, after the 4th data bit.
    step(1'b0, 1'b0, 1, 8'h5A, 1'b0);
    for (int i = 0; i < 4; i++) step(i[0] ? 1'b1 : 1'b0, 1'b0, 0, 8'h5A, 1'b0);
    bus.data = 1'b1;
    clear    = 1'b0;
    #2;
    model_clear();
    check_all("async_clear");
    chk("clear_busy", bus.busy, 1'b0);
    @(posedge clock);
    #1;
    clear = 1'b1;
    check_all("after_clear");
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_clear_q", bus.q, 8'hA5);
    chk("post_clear_valid", bus.valid, 1'b1);

`ifdef PARITY_CHECK_EN
    do_reset();
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("par_bad_ferr", bus.frame_err, 1'b1);
    chk("par_bad_valid", bus.valid, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("par_good_q", bus.q, 8'h07);
    chk("par_good_valid", bus.valid, 1'b1);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int f = 0; f < 60; f++) begin
      logic [7:0] w;
      logic       stp;
      bit         pf;
      int         gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step(1'b1, ($urandom_range(0, 2) == 0), 0, 8'h00, 1'b0);
      w   = 8'($urandom);
      stp = ($urandom_range(0, 7) != 0);
`ifdef PARITY_CHECK_EN
      pf  = ($urandom_range(0, 7) == 0);
`else
      pf  = 1'b0;
`endif
      send_frame(w, stp, pf, ($urandom_range(0, 1) == 0), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
